// File: rtl/led_status_if.sv
// led_status_if: status inputs and LED outputs of the status-LED sequencer.
//   busy_i     level, accelerator running
//   done_pulse one-cycle pulse, layer/inference complete
//   err_pulse  one-cycle pulse, fault detected
//   err_clr    one-cycle pulse, fault acknowledged
//   led        LED drive, 1 = on
//   state_o    sequencer state (0 IDLE, 1 BUSY, 2 CODE, 3 ERROR)
//   tick_o     blink time-base tick (combinational)
interface led_status_if;
    logic       busy_i;
    logic       done_pulse;
    logic       err_pulse;
    logic       err_clr;
    logic       led;
    logic [1:0] state_o;
    logic       tick_o;

    modport master (
        output busy_i, done_pulse, err_pulse, err_clr,
        input  led, state_o, tick_o
    );

    modport slave (
        input  busy_i, done_pulse, err_pulse, err_clr,
        output led, state_o, tick_o
    );
endinterface

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: drives the single board LED from three prioritised status
// sources: sticky error (repeating blink bursts), layer-done (one-shot N-blink
// code) and busy (steady toggle). A free-running prescaler sets the blink rate.
// Ports:
//   clk  system clock, posedge
//   rst  synchronous active-high reset
//   bus  led_status_if.slave: busy_i, done_pulse, err_pulse, err_clr in;
//        led, state_o (registered) and tick_o (combinational) out
module led_status_ctrl #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter int unsigned DONE_BLINKS = 3,
    parameter int unsigned ERR_BLINKS  = 2,
    parameter int unsigned GAP_TICKS   = 4
) (
    input  logic         clk,
    input  logic         rst,
    led_status_if.slave  bus
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CODE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    logic [PRESCALE_W-1:0] presc;
    state_t                state, state_n;
    logic                  led_q, led_n;
    logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
    logic                  gap, gap_n;
    logic                  done_pend, done_pend_n;
    logic                  err_flag, err_flag_n;
    logic                  tick;
    logic                  pe_run;
    logic                  code_entry;

    // Tick is suppressed while reset is held so it reads 0 during reset.
    assign tick    = (presc == {PRESCALE_W{1'b1}}) && !rst;
    assign cnt_inc = cnt + CNT_W'(1);

    assign bus.tick_o  = tick;
    assign bus.led     = led_q;
    assign bus.state_o = state;

    // State, blink registers, prescaler and pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            state     <= ST_IDLE;
            led_q     <= 1'b0;
            cnt       <= '0;
            gap       <= 1'b0;
            done_pend <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            presc     <= presc + PRESCALE_W'(1);
            state     <= state_n;
            led_q     <= led_n;
            cnt       <= cnt_n;
            gap       <= gap_n;
            done_pend <= done_pend_n;
            err_flag  <= err_flag_n;
        end
    end

    // Next-state logic: blink stepping per state, then priority evaluation.
    always_comb begin
        state_n     = state;
        led_n       = led_q;
        cnt_n       = cnt;
        gap_n       = gap;
        pe_run      = 1'b0;
        code_entry  = 1'b0;
        done_pend_n = done_pend;
        err_flag_n  = err_flag;

        if (tick) begin
            unique case (state)
                ST_IDLE, ST_BUSY: pe_run = 1'b1;

                // A fault aborts the code; PE then picks ERROR since err_flag wins.
                ST_CODE: begin
                    if (err_flag) begin
                        pe_run = 1'b1;
                    end else if (led_q) begin
                        led_n = 1'b0;
                    end else if (cnt_inc == CNT_W'(DONE_BLINKS)) begin
                        pe_run = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                        led_n = 1'b1;
                    end
                end

                ST_ERROR: begin
                    if (!err_flag) begin
                        pe_run = 1'b1;
                    end else if (!gap) begin
                        if (led_q) begin
                            led_n = 1'b0;
                        end else if (cnt_inc == CNT_W'(ERR_BLINKS)) begin
                            gap_n = 1'b1;
                            cnt_n = '0;
                            led_n = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                            led_n = 1'b1;
                        end
                    end else begin
                        if (cnt_inc == CNT_W'(GAP_TICKS)) begin
                            gap_n = 1'b0;
                            cnt_n = '0;
                            led_n = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end

                default: pe_run = 1'b1;
            endcase

            if (pe_run) begin
                if (err_flag) begin
                    state_n = ST_ERROR;
                    led_n   = 1'b1;
                    cnt_n   = '0;
                    gap_n   = 1'b0;
                end else if (done_pend) begin
                    state_n    = ST_CODE;
                    led_n      = 1'b1;
                    cnt_n      = '0;
                    code_entry = 1'b1;
                end else if (bus.busy_i) begin
                    state_n = ST_BUSY;
                    led_n   = (state == ST_BUSY) ? !led_q : 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    led_n   = 1'b0;
                end
            end
        end

        // Flags update every cycle; a new pulse beats a same-cycle clear.
        if (code_entry)     done_pend_n = 1'b0;
        if (bus.done_pulse) done_pend_n = 1'b1;
        if (bus.err_clr)    err_flag_n  = 1'b0;
        if (bus.err_pulse)  err_flag_n  = 1'b1;
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl: one vector = one 16-cycle tick period. Pulses are driven
// in cycle 3 of the period (optionally also in cycle 15, the tick cycle), busy
// is held for the whole period, and led/state_o are checked after the tick edge.
module tb_led_status_ctrl;

    localparam int unsigned PW     = 4;
    localparam int          PERIOD = 16;

    typedef struct {
        logic       busy;
        logic       done;
        logic       done15;
        logic       err;
        logic       clr;
        logic       led;
        logic [1:0] st;
    } vec_t;

    logic clk;
    logic rst;
    led_status_if bus ();

    led_status_ctrl #(
        .PRESCALE_W (PW),
        .DONE_BLINKS(3),
        .ERR_BLINKS (2),
        .GAP_TICKS  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cur_led = 0;
    int   cur_st  = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", nm, idx, act, exp_v);
        end
    endtask

    task automatic add(input int b, input int d, input int d15, input int e, input int c,
                       input int l, input int s);
        vec_t v;
        v.busy   = (b != 0);
        v.done   = (d != 0);
        v.done15 = (d15 != 0);
        v.err    = (e != 0);
        v.clr    = (c != 0);
        v.led    = (l != 0);
        v.st     = 2'(s);
        vecs.push_back(v);
    endtask

    // Idle-input periods with expected led values, all in state s.
    task automatic add_idle(input int s, input int leds[$]);
        foreach (leds[i]) add(0, 0, 0, 0, 0, leds[i], s);
    endtask

    // Entered at the negedge of cycle 0 of a period; returns at cycle 0 of the next.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        exp_q.push_back(v);
        for (int k = 0; k < PERIOD; k++) begin
            chk("tick_o", idx, int'(bus.tick_o), int'(k == PERIOD - 1));
            if (k == 8) begin
                chk("led_hold", idx, int'(bus.led), cur_led);
                chk("state_hold", idx, int'(bus.state_o), cur_st);
            end
            bus.busy_i     = v.busy;
            bus.done_pulse = (v.done && k == 3) || (v.done15 && k == PERIOD - 1);
            bus.err_pulse  = v.err && k == 3;
            bus.err_clr    = v.clr && k == 3;
            @(negedge clk);
        end
        bus.done_pulse = 1'b0;
        bus.err_pulse  = 1'b0;
        bus.err_clr    = 1'b0;
        e = exp_q.pop_front();
        chk("led", idx, int'(bus.led), int'(e.led));
        chk("state_o", idx, int'(bus.state_o), int'(e.st));
        cur_led = int'(e.led);
        cur_st  = int'(e.st);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end, got %0d vectors, expected completion", n_vec);
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.busy_i     = 1'b0;
        bus.done_pulse = 1'b0;
        bus.err_pulse  = 1'b0;
        bus.err_clr    = 1'b0;

        // Idle after reset.
        add_idle(0, '{0, 0});
        // Busy toggling, then drop.
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Single done code: 1,0,1,0,1,0 then IDLE.
        add(0, 1, 0, 0, 0, 1, 2);
        add_idle(2, '{0, 1, 0, 1, 0});
        add_idle(0, '{0});
        // Error aborts a code; burst 1,0,1,0,0,0,0,0 repeats; clear with busy.
        add(0, 1, 0, 0, 0, 1, 2);
        add(0, 0, 0, 1, 0, 1, 3);
        add_idle(3, '{0, 1, 0, 0, 0, 0, 0, 1, 0});
        add(1, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Two done pulses during a code merge into exactly one more code.
        add(0, 1, 0, 0, 0, 1, 2);
        add(0, 1, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0, 1, 2);
        add_idle(2, '{0, 1, 0, 1, 0, 1, 0, 1, 0});
        add_idle(0, '{0});
        // Done held during ERROR and played after err_clr.
        add(0, 0, 0, 1, 0, 1, 3);
        add(0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 1, 1, 2);
        add_idle(2, '{0, 1, 0, 1, 0});
        add_idle(0, '{0});
        // done_pulse in the CODE-entry cycle survives the entry clear.
        add(0, 1, 1, 0, 0, 1, 2);
        add_idle(2, '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0});
        add_idle(0, '{0});
        // Done outranks busy; code returns to BUSY with led on.
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // err_pulse + err_clr (+ done) in one cycle: error wins.
        add(0, 1, 0, 1, 1, 1, 3);

        repeat (3) @(negedge clk);
        chk("rst_led", -1, int'(bus.led), 0);
        chk("rst_state_o", -1, int'(bus.state_o), 0);
        chk("rst_tick_o", -1, int'(bus.tick_o), 0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-ERROR with led on and a done request pending.
        for (int k = 0; k < 5; k++) begin
            chk("tick_o_pre_rst", k, int'(bus.tick_o), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_led", 0, int'(bus.led), 0);
        chk("mid_rst_state_o", 0, int'(bus.state_o), 0);
        chk("mid_rst_tick_o", 0, int'(bus.tick_o), 0);
        @(negedge clk);
        rst     = 1'b0;
        cur_led = 0;
        cur_st  = 0;
        begin
            vec_t v;
            v = '{busy: 1'b0, done: 1'b0, done15: 1'b0, err: 1'b0, clr: 1'b0,
                  led: 1'b0, st: 2'd0};
            apply(v, 1000);
            apply(v, 1001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
